// File: rtl/axi_pkg.sv
// Shared AXI definitions for the burst read slave.
//   - axi_burst_e : ARBURST encodings (FIXED / INCR / WRAP / reserved)
//   - RESP_*      : RRESP codes
//   - eng_state_e : read engine states
//   - wrap_len_legal() : WRAP bursts are only legal for 2, 4, 8 or 16 beats
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } axi_burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        ENG_IDLE  = 1'b0,
        ENG_BURST = 1'b1
    } eng_state_e;

    function automatic logic wrap_len_legal(input logic [31:0] len);
        return (len == 32'd1) || (len == 32'd3) || (len == 32'd7) || (len == 32'd15);
    endfunction

endpackage

// File: rtl/axi_sync_fifo.sv
// Synchronous descriptor FIFO with fall-through when empty.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   push_i, wdata_i : write request / data (ignored while full)
//   pop_i, rdata_o  : read request / head data
//   full_o          : all DEPTH entries stored (registered status)
//   empty_o         : no data available; a push in the same cycle counts as
//                     available, so an empty FIFO can be pushed and popped at once
module axi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic stored_empty, push_ok, pop_ok, wr_en, rd_en;

    assign stored_empty = (count_q == '0);
    assign full_o       = (count_q == FULL_CNT);
    assign push_ok      = push_i & ~full_o;
    assign empty_o      = stored_empty & ~push_ok;
    assign pop_ok       = pop_i & ~empty_o;
    // A push popped in the same cycle into an empty FIFO never touches storage.
    assign wr_en        = push_ok & ~(pop_ok & stored_empty);
    assign rd_en        = pop_ok & ~stored_empty;
    assign rdata_o      = stored_empty ? wdata_i : mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + {{PTR_W{1'b0}}, wr_en} - {{PTR_W{1'b0}}, rd_en};
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/axi_slave_burst_reader.sv
// AXI read-channel slave serving FIXED/INCR/WRAP bursts from a synchronous
// memory with one cycle of read latency.
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   AR*                       : read address channel (descriptors queued in a FIFO)
//   R*                        : read data channel (2-entry output buffer)
//   mem_rd_en/addr/data       : memory read port, data valid one cycle after en
module axi_slave_burst_reader
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int AR_DEPTH   = 4,
    parameter int MEM_WORDS  = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic                         ARREADY,
    input  logic                         ARVALID,
    input  logic [ADDR_WIDTH-1:0]        ARADDR,
    input  logic [LEN_WIDTH-1:0]         ARLEN,
    input  logic [2:0]                   ARSIZE,
    input  logic [1:0]                   ARBURST,
    output logic                         RVALID,
    output logic [DATA_WIDTH-1:0]        RDATA,
    output logic [1:0]                   RRESP,
    output logic                         RLAST,
    input  logic                         RREADY,
    output logic                         mem_rd_en,
    output logic [$clog2(MEM_WORDS)-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]        mem_rd_data
);
    localparam int BYTE_SHIFT = $clog2(DATA_WIDTH/8);
    localparam int MEM_AW     = $clog2(MEM_WORDS);
    localparam int DESC_W     = ADDR_WIDTH + LEN_WIDTH + 3 + 2;

    // ---------------- AR descriptor queue ----------------
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DESC_W-1:0] fifo_rdata;
    logic [ADDR_WIDTH-1:0] pop_addr;
    logic [LEN_WIDTH-1:0]  pop_len;
    logic [2:0]            pop_size;
    logic [1:0]            pop_burst;
    logic                  pop_err;

    // Held low during reset even though the FIFO status is already "not full".
    assign ARREADY   = rst_n & ~fifo_full;
    assign fifo_push = ARVALID & ARREADY;

    axi_sync_fifo #(
        .WIDTH (DESC_W),
        .DEPTH (AR_DEPTH)
    ) u_ar_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .wdata_i ({ARADDR, ARLEN, ARSIZE, ARBURST}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign {pop_addr, pop_len, pop_size, pop_burst} = fifo_rdata;
    assign pop_err = (pop_size > 3'(BYTE_SHIFT))
                   || (pop_burst == BURST_RSVD)
                   || ((pop_burst == BURST_WRAP) && !wrap_len_legal(32'(pop_len)));

    // ---------------- Engine ----------------
    eng_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, next_addr;
    logic [LEN_WIDTH-1:0]  len_q, len_d, cnt_q, cnt_d;
    logic [2:0]            size_q, size_d;
    axi_burst_e            burst_q, burst_d;
    logic                  berr_q, berr_d;
    logic [ADDR_WIDTH-1:0] size_bytes, wrap_mask, incr_addr, word_addr;
    logic                  beat_err, last_beat, issue, can_issue, r_pop;
    logic [2:0]            pending;

    // In-flight read stage (aligned with mem_rd_data).
    logic infl_vld_q, infl_err_q, infl_last_q;

    // R output buffer
    logic [DATA_WIDTH-1:0] rbuf_data_q [2];
    logic [1:0]            rbuf_resp_q [2];
    logic                  rbuf_last_q [2];
    logic                  rbuf_wr_q, rbuf_rd_q;
    logic [1:0]            rcnt_q, rcnt_d;

    assign size_bytes = ADDR_WIDTH'(1) << size_q;
    assign wrap_mask  = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
    assign incr_addr  = addr_q + size_bytes;

    always_comb begin
        next_addr = addr_q;
        case (burst_q)
            BURST_INCR: next_addr = incr_addr;
            // Low bits advance within the wrap window, high bits stay on its base.
            BURST_WRAP: next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
            default:    next_addr = addr_q;
        endcase
    end

    assign word_addr = addr_q >> BYTE_SHIFT;
    assign beat_err  = berr_q | (word_addr >= ADDR_WIDTH'(MEM_WORDS));
    assign last_beat = (cnt_q == len_q);

    // Credit: buffer entries + read in flight, less the entry leaving this
    // cycle, must leave room for the beat about to be issued.
    assign r_pop     = RVALID & RREADY;
    assign pending   = {1'b0, rcnt_q} + {2'b00, infl_vld_q} - {2'b00, r_pop};
    assign can_issue = (pending < 3'd2);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        size_d   = size_q;
        burst_d  = burst_q;
        cnt_d    = cnt_q;
        berr_d   = berr_q;
        fifo_pop = 1'b0;
        issue    = 1'b0;
        case (state_q)
            ENG_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    addr_d   = pop_addr;
                    len_d    = pop_len;
                    size_d   = pop_size;
                    burst_d  = axi_burst_e'(pop_burst);
                    berr_d   = pop_err;
                    cnt_d    = '0;
                    state_d  = ENG_BURST;
                end
            end
            default: begin
                if (can_issue) begin
                    issue = 1'b1;
                    if (last_beat) begin
                        state_d = ENG_IDLE;
                    end else begin
                        cnt_d  = cnt_q + LEN_WIDTH'(1);
                        addr_d = next_addr;
                    end
                end
            end
        endcase
    end

    assign mem_rd_en   = issue & ~beat_err;
    assign mem_rd_addr = word_addr[MEM_AW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ENG_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= BURST_FIXED;
            cnt_q       <= '0;
            berr_q      <= 1'b0;
            infl_vld_q  <= 1'b0;
            infl_err_q  <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            cnt_q       <= cnt_d;
            berr_q      <= berr_d;
            infl_vld_q  <= issue;
            infl_err_q  <= beat_err;
            infl_last_q <= last_beat;
        end
    end

    // ---------------- R output buffer ----------------
    assign rcnt_d = rcnt_q + {1'b0, infl_vld_q} - {1'b0, r_pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rbuf_wr_q <= 1'b0;
            rbuf_rd_q <= 1'b0;
            rcnt_q    <= '0;
        end else begin
            if (infl_vld_q) rbuf_wr_q <= ~rbuf_wr_q;
            if (r_pop)      rbuf_rd_q <= ~rbuf_rd_q;
            rcnt_q <= rcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (infl_vld_q) begin
            rbuf_data_q[rbuf_wr_q] <= infl_err_q ? '0 : mem_rd_data;
            rbuf_resp_q[rbuf_wr_q] <= infl_err_q ? RESP_SLVERR : RESP_OKAY;
            rbuf_last_q[rbuf_wr_q] <= infl_last_q;
        end
    end

    // Outputs are forced to zero whenever the buffer is empty.
    assign RVALID = (rcnt_q != 2'd0);
    assign RDATA  = RVALID ? rbuf_data_q[rbuf_rd_q] : '0;
    assign RRESP  = RVALID ? rbuf_resp_q[rbuf_rd_q] : RESP_OKAY;
    assign RLAST  = RVALID & rbuf_last_q[rbuf_rd_q];

endmodule
